// File: rtl/zombie_lane_engine.sv
// Zombie gameplay engine: one zombie per lawn lane, spawn/kill handshakes,
// one-hot level FSM with kill counting, and a per-pixel zombie flag for the colour mux.
module zombie_lane_engine #(
  parameter int LANES           = 5,
  parameter int LANE_TOP        = 160,
  parameter int LANE_H          = 128,
  parameter int SPAWN_X         = 639,
  parameter int END_X           = 0,
  parameter int ZW              = 32,
  parameter int TICK_DIV        = 500000,
  parameter int KILLS_PER_LEVEL = 10,
  localparam int LW             = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  spawn_valid,
  input  logic [LW-1:0]         spawn_lane,
  output logic                  spawn_ready,
  input  logic                  kill_valid,
  input  logic [LW-1:0]         kill_lane,
  input  logic [9:0]            hCount,
  input  logic [9:0]            vCount,
  output logic                  zombie_pix,
  output logic [LANES-1:0]      lane_active,
  output logic [10*LANES-1:0]   zombie_x,
  output logic [15:0]           zombies_killed,
  output logic [7:0]            state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [7:0] {
    S_I     = 8'h01,
    S_L1    = 8'h02,
    S_NL2   = 8'h04,
    S_L2    = 8'h08,
    S_NL3   = 8'h10,
    S_L3    = 8'h20,
    S_DONEL = 8'h40,
    S_DONEW = 8'h80
  } state_t;

  state_t           state_q, state_d;
  logic [LANES-1:0] active_q, active_d;
  logic [9:0]       x_q [LANES];
  logic [9:0]       x_d [LANES];
  logic [15:0]      killed_q, killed_d;
  logic [15:0]      lvl_q, lvl_d;
  logic [TW-1:0]    tick_q, tick_d;

  logic             play;
  logic [9:0]       step;
  logic             tick_fire;
  logic             kill_acc;
  logic             spawn_xfer;
  logic             lose;
  logic             level_done;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    play = 1'b0;
    step = 10'd0;
    case (state_q)
      S_L1:    begin play = 1'b1; step = 10'd1; end
      S_L2:    begin play = 1'b1; step = 10'd2; end
      S_L3:    begin play = 1'b1; step = 10'd3; end
      default: begin play = 1'b0; step = 10'd0; end
    endcase
  end

  assign tick_fire = play && (tick_q == TW'(TICK_DIV - 1));

  // Handshakes look only at registered lane_active, so a same-cycle kill never frees a lane for spawn.
  always_comb begin
    spawn_ready = 1'b0;
    kill_acc    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (spawn_lane == LW'(i) && !active_q[i]) spawn_ready = play;
      if (kill_lane == LW'(i) && active_q[i])   kill_acc    = play && kill_valid;
    end
  end

  assign spawn_xfer = spawn_valid && spawn_ready;

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    x_d        = x_q;
    killed_d   = killed_q;
    lvl_d      = lvl_q;
    tick_d     = '0;
    lose       = 1'b0;
    level_done = 1'b0;

    if (play) tick_d = tick_fire ? '0 : tick_q + TW'(1);

    // A killed lane skips its movement, so it cannot trigger a loss on the same tick.
    for (int i = 0; i < LANES; i++) begin
      if (kill_acc && kill_lane == LW'(i)) begin
        active_d[i] = 1'b0;
      end else if (spawn_xfer && spawn_lane == LW'(i)) begin
        active_d[i] = 1'b1;
        x_d[i]      = 10'(SPAWN_X);
      end else if (tick_fire && active_q[i]) begin
        if ({1'b0, x_q[i]} <= 11'(END_X) + {1'b0, step}) begin
          x_d[i] = 10'(END_X);
          lose   = 1'b1;
        end else begin
          x_d[i] = x_q[i] - step;
        end
      end
    end

    if (kill_acc) begin
      killed_d   = sat_inc16(killed_q);
      lvl_d      = lvl_q + 16'd1;
      level_done = (lvl_q + 16'd1) >= 16'(KILLS_PER_LEVEL);
    end

    // Level completion is tested before loss so it wins a same-edge race.
    case (state_q)
      S_I:     if (start) begin state_d = S_L1; killed_d = '0; end
      S_L1:    if (level_done) state_d = S_NL2;   else if (lose) state_d = S_DONEL;
      S_L2:    if (level_done) state_d = S_NL3;   else if (lose) state_d = S_DONEL;
      S_L3:    if (level_done) state_d = S_DONEW; else if (lose) state_d = S_DONEL;
      S_NL2:   if (start) state_d = S_L2;
      S_NL3:   if (start) state_d = S_L3;
      S_DONEL: if (start) state_d = S_I;
      S_DONEW: if (start) state_d = S_I;
      default: state_d = S_I;
    endcase

    if (state_d != state_q && state_d != S_L1 && state_d != S_L2 && state_d != S_L3) begin
      active_d = '0;
      lvl_d    = '0;
      tick_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_I;
      active_q <= '0;
      for (int i = 0; i < LANES; i++) x_q[i] <= 10'(SPAWN_X);
      killed_q <= '0;
      lvl_q    <= '0;
      tick_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      for (int i = 0; i < LANES; i++) x_q[i] <= x_d[i];
      killed_q <= killed_d;
      lvl_q    <= lvl_d;
      tick_q   <= tick_d;
    end
  end

  // Pixel flag uses 11-bit bounds so the sprite's right edge and lower lanes never wrap.
  always_comb begin
    logic [10:0] row_lo;
    logic [10:0] row_hi;
    logic [10:0] col_lo;
    logic [10:0] col_hi;
    row_lo     = '0;
    row_hi     = '0;
    col_lo     = '0;
    col_hi     = '0;
    zombie_pix = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      row_lo = 11'(LANE_TOP + i * LANE_H);
      row_hi = 11'(LANE_TOP + (i + 1) * LANE_H - 1);
      col_lo = {1'b0, x_q[i]};
      col_hi = {1'b0, x_q[i]} + 11'(ZW - 1);
      if (active_q[i] &&
          {1'b0, vCount} >= row_lo && {1'b0, vCount} <= row_hi &&
          {1'b0, hCount} >= col_lo && {1'b0, hCount} <= col_hi)
        zombie_pix = 1'b1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign zombie_x[10*g +: 10] = x_q[g];
  end

  assign lane_active    = active_q;
  assign zombies_killed = killed_q;
  assign state          = state_q;

endmodule
